// File: rtl/rf_safety_pkg.sv
// rtl/rf_safety_pkg.sv - shared state encoding and gain constants for the RF safe-shutdown block
package rf_safety_pkg;

  typedef enum logic [2:0] {
    ST_MUTED     = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD      = 3'd4
  } rf_state_e;

  localparam int DEF_DATA_W = 14;
  localparam int DEF_GAIN_W = 8;
  localparam int DEF_UNITY  = 1 << DEF_GAIN_W;

  function automatic int unity_gain(input int gain_w);
    return 1 << gain_w;
  endfunction

endpackage

// File: rtl/shutdown_ramp.sv
// rtl/shutdown_ramp.sv - tick prescaler plus saturating up/down gain counter (0..unity)
module shutdown_ramp
  import rf_safety_pkg::*;
#(
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_DIV  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dir,
  input  logic            hold,
  input  logic            set_unity,
  input  logic            zero,
  output logic [GAIN_W:0] gain,
  output logic            at_min,
  output logic            at_max
);

  localparam int GW = GAIN_W + 1;
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [GW:0]     UNITY_X = (GW + 1)'(unity_gain(GAIN_W));
  localparam logic [GW:0]     STEP_X  = (GW + 1)'(RAMP_STEP);
  localparam logic [GW-1:0]   UNITY_G = GW'(unity_gain(GAIN_W));
  localparam logic [GW-1:0]   STEP_G  = GW'(RAMP_STEP);
  localparam logic [PW-1:0]   DIV_TOP = PW'(RAMP_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [GW-1:0] gain_q, gain_d;
  logic [GW:0]   up_sum;
  logic          tick;

  // hold doubles as the prescaler restart so every new ramp phase starts a full tick period
  assign tick   = !hold && (presc_q == DIV_TOP);
  assign up_sum = {1'b0, gain_q} + STEP_X;

  always_comb begin
    presc_d = (hold || tick) ? '0 : presc_q + 1'b1;
    gain_d  = gain_q;
    if (zero) begin
      gain_d = '0;
    end else if (set_unity) begin
      gain_d = UNITY_G;
    end else if (tick) begin
      if (dir) begin
        gain_d = (up_sum >= UNITY_X) ? UNITY_G : up_sum[GW-1:0];
      end else begin
        gain_d = ({1'b0, gain_q} <= STEP_X) ? '0 : gain_q - STEP_G;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
      gain_q  <= '0;
    end else begin
      presc_q <= presc_d;
      gain_q  <= gain_d;
    end
  end

  assign gain   = gain_q;
  assign at_min = (gain_q == '0);
  assign at_max = (gain_q == UNITY_G);

endmodule

// File: rtl/rf_safe_shutdown.sv
// rtl/rf_safe_shutdown.sv - watchdog-driven carrier ramp-down, DAC gating and latched fault
// Optional feature macro: RF_SHUTDOWN_WARN_ATTEN_EN (halves gain while warning is high in RUN).
module rf_safe_shutdown
  import rf_safety_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_DIV  = 4,
  parameter int FCNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     force_reset,
  input  logic                     warning,
  input  logic                     arm,
  input  logic                     clear_fault,
  input  logic signed [DATA_W-1:0] amp_in,
  output logic signed [DATA_W-1:0] amp_out,
  output logic                     dac_en,
  output logic                     fault,
  output logic [2:0]               state,
  output logic [FCNT_W-1:0]        fault_count
);

  localparam int PW = DATA_W + GAIN_W + 2;

  rf_state_e               state_q, state_d;
  logic                    trip_q, trip_d;
  logic                    fault_q, fault_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  logic                    dac_en_q, dac_en_d;
  logic signed [DATA_W-1:0] amp_q, amp_d;
  logic                    do_trip;

  logic [GAIN_W:0]         gain;
  logic                    at_min, at_max;
  logic                    ramp_hold;
  logic signed [PW-1:0]    prod, shifted;

  always_comb begin
    state_d = state_q;
    trip_d  = trip_q;
    fault_d = fault_q;
    do_trip = 1'b0;
    case (state_q)
      ST_MUTED: begin
        if (force_reset) begin
          state_d = ST_HOLD;
          do_trip = 1'b1;
        end else if (arm && !fault_q) begin
          state_d = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP, ST_RUN: begin
        if (force_reset) begin
          state_d = ST_RAMP_DOWN;
          do_trip = 1'b1;
        end else if (!arm) begin
          state_d = ST_RAMP_DOWN;
        end else if (state_q == ST_RAMP_UP && at_max) begin
          state_d = ST_RUN;
        end
      end
      ST_RAMP_DOWN: begin
        // a trip arriving during a host-initiated ramp-down still latches and counts once
        if (force_reset && !trip_q) begin
          do_trip = 1'b1;
        end else if (arm && !trip_q) begin
          state_d = ST_RAMP_UP;
        end else if (at_min) begin
          state_d = trip_q ? ST_HOLD : ST_MUTED;
        end
      end
      ST_HOLD: begin
        if (clear_fault && !force_reset) begin
          state_d = ST_MUTED;
          fault_d = 1'b0;
          trip_d  = 1'b0;
        end
      end
      default: state_d = ST_MUTED;
    endcase
    if (do_trip) begin
      trip_d  = 1'b1;
      fault_d = 1'b1;
    end
    fcnt_d   = (do_trip && (fcnt_q != '1)) ? fcnt_q + 1'b1 : fcnt_q;
    dac_en_d = (state_d == ST_RAMP_UP) || (state_d == ST_RUN) || (state_d == ST_RAMP_DOWN);
  end

  // freeze the gain on the edge that changes state so a reversal starts from the current level
  assign ramp_hold = (state_d != state_q) ||
                     !((state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN));

  shutdown_ramp #(
    .GAIN_W   (GAIN_W),
    .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk      (clk),
    .rstn     (rstn),
    .dir      (state_q == ST_RAMP_UP),
    .hold     (ramp_hold),
    .set_unity(state_q == ST_RUN),
    .zero     ((state_q == ST_MUTED) || (state_q == ST_HOLD)),
    .gain     (gain),
    .at_min   (at_min),
    .at_max   (at_max)
  );

  assign prod = PW'(amp_in) * PW'($signed({1'b0, gain}));

`ifdef RF_SHUTDOWN_WARN_ATTEN_EN
  assign shifted = (warning && (state_q == ST_RUN)) ? (prod >>> (GAIN_W + 1)) : (prod >>> GAIN_W);
`else
  logic unused_warning;
  assign unused_warning = warning;
  assign shifted = prod >>> GAIN_W;
`endif

  assign amp_d = shifted[DATA_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_MUTED;
      trip_q   <= 1'b0;
      fault_q  <= 1'b0;
      fcnt_q   <= '0;
      dac_en_q <= 1'b0;
      amp_q    <= '0;
    end else begin
      state_q  <= state_d;
      trip_q   <= trip_d;
      fault_q  <= fault_d;
      fcnt_q   <= fcnt_d;
      dac_en_q <= dac_en_d;
      amp_q    <= amp_d;
    end
  end

  assign amp_out     = amp_q;
  assign dac_en      = dac_en_q;
  assign fault       = fault_q;
  assign state       = state_q;
  assign fault_count = fcnt_q;

endmodule
